// File: rtl/cnn_frame_loader.sv
// Feeds one 8-bit pixel frame into the accelerator's f1 RAM as 32-bit words, kicks off
// a run, and holds the classification result on a valid/ready port until it is consumed.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------------
//  LOAD      | accept pixels, pack 4 per word, write each completed word
//  START     | single-cycle start pulse to the accelerator
//  WAIT_DONE | wait for done, abort with frame_err after TIMEOUT cycles
//  RESULT    | hold res_value/res_index valid until res_ready
module cnn_frame_loader #(
    parameter int PIX_NUM = 1024,
    parameter int TIMEOUT = 2000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic [3:0]  f1_wr_en,
    output logic [31:0] f1_waddr,
    output logic [31:0] f1_wdata,
    output logic        ena,
    output logic        start,
    input  logic        done,
    input  logic [15:0] class_value,
    input  logic [3:0]  class_index,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_value,
    output logic [3:0]  res_index,
    output logic        busy,
    output logic        frame_err
);

    localparam int              CW       = $clog2(PIX_NUM);
    localparam logic [CW-1:0]   LAST_PIX = CW'(PIX_NUM - 1);
    localparam logic [31:0]     TO_LAST  = 32'(TIMEOUT - 1);

    typedef enum logic [1:0] {LOAD, START, WAIT_DONE, RESULT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] pix_cnt;
    logic [23:0]   lane_buf;
    logic          frame_full;
    logic [31:0]   to_cnt;
    logic          wr_pend;
    logic          err_q;
    logic          accept;
    logic          last_pix;
    logic          early_end;

    always_comb begin
        state_nxt = state;
        s_ready   = (state == LOAD) && !frame_full;
        accept    = s_valid && s_ready;
        last_pix  = (pix_cnt == LAST_PIX);
        early_end = accept && s_last && !last_pix;
        start     = (state == START);
        busy      = (state != LOAD);
        res_valid = (state == RESULT);
        case (state)
            LOAD:      if (frame_full) state_nxt = START;
            START:     state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                if (done)                  state_nxt = RESULT;
                else if (to_cnt == TO_LAST) state_nxt = LOAD;
            end
            RESULT:    if (res_ready) state_nxt = LOAD;
            default:   state_nxt = LOAD;
        endcase
    end

    assign f1_wr_en  = {4{wr_pend}};
    assign ena       = wr_pend;
    assign frame_err = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_cnt    <= '0;
            lane_buf   <= '0;
            frame_full <= 1'b0;
            to_cnt     <= '0;
            wr_pend    <= 1'b0;
            err_q      <= 1'b0;
            f1_waddr   <= '0;
            f1_wdata   <= '0;
            res_value  <= '0;
            res_index  <= '0;
        end else begin
            wr_pend <= 1'b0;
            err_q   <= 1'b0;

            if (state == LOAD) begin
                // frame_full marks the final-write cycle; s_ready is already low
                if (frame_full) begin
                    frame_full <= 1'b0;
                end else if (accept) begin
                    if (early_end) begin
                        pix_cnt <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        pix_cnt    <= last_pix ? '0 : pix_cnt + 1'b1;
                        frame_full <= last_pix;
                        case (pix_cnt[1:0])
                            2'd0: lane_buf[7:0]   <= s_data;
                            2'd1: lane_buf[15:8]  <= s_data;
                            2'd2: lane_buf[23:16] <= s_data;
                            default: begin
                                wr_pend  <= 1'b1;
                                f1_waddr <= 32'({pix_cnt[CW-1:2], 2'b00});
                                f1_wdata <= {s_data, lane_buf};
                            end
                        endcase
                    end
                end
            end

            if (state == START) to_cnt <= '0;

            if (state == WAIT_DONE) begin
                if (done) begin
                    res_value <= class_value;
                    res_index <= class_index;
                end else if (to_cnt == TO_LAST) begin
                    err_q <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

endmodule
